sar_search: RTL

SAR_SEARCH -- requirements
Module: sar_search

---
 rtl/sar_search_if.sv | 26 ++
 rtl/sar_search.sv | 118 +++++++++++
 2 files changed

// File: rtl/sar_search_if.sv
// Bus between the SAR search engine and its external comparator / requester.
// The slave side is the search engine; the master side drives start and the comparator flags.
interface sar_search_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] trial;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             cmp_gt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             err;

  modport master (
    output start, cmp_eq, cmp_lt, cmp_gt,
    input  trial, busy, done, result, found, err
  );

  modport slave (
    input  start, cmp_eq, cmp_lt, cmp_gt,
    output trial, busy, done, result, found, err
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search: probes an external comparator MSB-first,
// exits early on equality, aborts on non-one-hot comparator feedback.
module sar_search #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  sar_search_if.slave bus
);
  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]    IDX_TOP = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB     = ONE << (WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             found_q, found_d;
  logic             err_q, err_d;

  logic [2:0]       cmp_code;
  logic             cmp_legal_ne;
  logic [WIDTH-1:0] acc_upd;

  assign cmp_code     = {bus.cmp_eq, bus.cmp_lt, bus.cmp_gt};
  assign cmp_legal_ne = (cmp_code == 3'b010) || (cmp_code == 3'b001);
  assign acc_upd      = bus.cmp_lt ? trial_q : acc_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = PROBE;
      PROBE:   if (!cmp_legal_ne || (idx_q == '0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; trial is precomputed so it is registered for the next probe
  always_comb begin
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    trial_d  = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          found_d = 1'b0;
          err_d   = 1'b0;
          idx_d   = IDX_TOP;
          trial_d = MSB;
        end
      end
      PROBE: begin
        if (cmp_code == 3'b100) begin
          result_d = trial_q;
          found_d  = 1'b1;
        end else if (cmp_legal_ne) begin
          acc_d = acc_upd;
          if (idx_q == '0) begin
            result_d = acc_upd;
            found_d  = 1'b0;
          end else begin
            idx_d   = idx_q - 1'b1;
            trial_d = acc_upd | (ONE << (idx_q - 1'b1));
          end
        end else begin
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = acc_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      idx_q    <= IDX_TOP;
      trial_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  // Output logic
  always_comb begin
    bus.trial  = trial_q;
    bus.busy   = (state_q != IDLE);
    bus.done   = (state_q == DONE);
    bus.result = result_q;
    bus.found  = found_q;
    bus.err    = err_q;
  end
endmodule
